// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush vectors from mem-wait, multi-cycle EX,
// branch redirect and load-use events. Optional debug counters under HAZARD_STATS_EN.
module hazard_ctrl #(
    parameter int NSTAGE     = 5,
    parameter int EX_STAGE   = 2,
    parameter int MEM_STAGE  = 3,
    parameter int MC_LAT     = 4,
    parameter int LU_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_change,
    input  logic              load_use_hazard,
    input  logic              mc_start,
    input  logic              mem_wait,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic              mc_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_events
`endif
);

    if (!(MEM_STAGE > EX_STAGE && EX_STAGE >= 2 && MEM_STAGE < NSTAGE)) begin : g_bad_stage
        $error("hazard_ctrl: illegal stage indices");
    end
    if (MC_LAT < 1 || MC_LAT > 255) begin : g_bad_lat
        $error("hazard_ctrl: MC_LAT out of range 1..255");
    end
    if (LU_BUBBLES < 1 || LU_BUBBLES > 2) begin : g_bad_lu
        $error("hazard_ctrl: LU_BUBBLES must be 1 or 2");
    end

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

    localparam logic [7:0] MC_INIT = (MC_LAT >= 2) ? 8'(MC_LAT - 2) : 8'd0;

    mc_state_e  mc_state_q, mc_state_d;
    logic [7:0] mc_cnt_q, mc_cnt_d;
    logic       lu_pend_q, lu_pend_d;
    logic       mc_stall_s, pc_act_s, lu_act_s;

    // Decide which single event source acts this cycle
    always_comb begin
        mc_stall_s = 1'b0;
        if (mc_state_q == MC_BUSY) begin
            mc_stall_s = 1'b1;
        end else if (mc_state_q == MC_IDLE && mc_start && MC_LAT >= 2) begin
            mc_stall_s = 1'b1;
        end else begin
            mc_stall_s = 1'b0;
        end
        pc_act_s = !mem_wait && !mc_stall_s && pc_change;
        lu_act_s = !mem_wait && !mc_stall_s && !pc_change && (load_use_hazard || lu_pend_q);
    end

    // Stall/flush vectors, forced quiet during reset
    always_comb begin
        stall   = '0;
        flush   = '0;
        mc_busy = 1'b0;
        if (rst) begin
            mc_busy = 1'b0;
        end else if (mem_wait) begin
            for (int i = 0; i < NSTAGE; i++) begin
                stall[i] = (i <= MEM_STAGE);
                flush[i] = (i == MEM_STAGE + 1);
            end
        end else if (mc_stall_s) begin
            mc_busy = 1'b1;
            for (int i = 0; i < NSTAGE; i++) begin
                stall[i] = (i <= EX_STAGE);
                flush[i] = (i == EX_STAGE + 1);
            end
        end else if (pc_act_s) begin
            for (int i = 0; i < NSTAGE; i++) begin
                flush[i] = (i >= 1 && i <= EX_STAGE);
            end
        end else if (lu_act_s) begin
            for (int i = 0; i < NSTAGE; i++) begin
                stall[i] = (i <= 1);
                flush[i] = (i == 2);
            end
        end else begin
            mc_busy = 1'b0;
        end
    end

    // Multi-cycle FSM and second load-use bubble next-state
    always_comb begin
        mc_state_d = mc_state_q;
        mc_cnt_d   = mc_cnt_q;
        lu_pend_d  = lu_pend_q;
        case (mc_state_q)
            MC_IDLE: begin
                if (!mem_wait && mc_start && MC_LAT >= 3) begin
                    mc_state_d = MC_BUSY;
                    mc_cnt_d   = MC_INIT;
                end else if (!mem_wait && mc_start && MC_LAT == 2) begin
                    mc_state_d = MC_DONE;
                end else begin
                    mc_state_d = MC_IDLE;
                end
            end
            MC_BUSY: begin
                // Counting continues under mem_wait so the op latency is not stretched
                if (mc_cnt_q <= 8'd1) begin
                    mc_state_d = MC_DONE;
                    mc_cnt_d   = 8'd0;
                end else begin
                    mc_cnt_d   = mc_cnt_q - 8'd1;
                end
            end
            MC_DONE: begin
                if (!mem_wait) begin
                    mc_state_d = MC_IDLE;
                end else begin
                    mc_state_d = MC_DONE;
                end
            end
            default: begin
                mc_state_d = MC_IDLE;
                mc_cnt_d   = 8'd0;
            end
        endcase

        if (LU_BUBBLES != 2) begin
            lu_pend_d = 1'b0;
        end else if (pc_act_s) begin
            lu_pend_d = 1'b0;
        end else if (lu_act_s) begin
            lu_pend_d = !lu_pend_q;
        end else begin
            lu_pend_d = lu_pend_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc_state_q <= MC_IDLE;
            mc_cnt_q   <= 8'd0;
            lu_pend_q  <= 1'b0;
        end else begin
            mc_state_q <= mc_state_d;
            mc_cnt_q   <= mc_cnt_d;
            lu_pend_q  <= lu_pend_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, flush_events_q;

    // Free-running debug counters, wrapping at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            flush_events_q <= 32'd0;
        end else begin
            if (stall[0]) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (pc_act_s) begin
                flush_events_q <= flush_events_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the RV32 in-order core.
- Generates per-stage stall (hold) and flush (bubble) vectors from four event sources: branch redirect, load-use, multi-cycle EX operation, data-memory wait.
- Owns a multi-cycle-op FSM with a latency counter and a second-bubble register for load-use without MEM->EX forwarding; the pipeline top instantiates it and fans the vectors out to stage registers.

Parameters:
- NSTAGE, 5: pipeline stage count; index 0=IF, 1=ID, 2=EX, 3=MEM, 4=WB.
- EX_STAGE, 2: stage index of multi-cycle unit and branch resolution.
- MEM_STAGE, 3: stage index of data-memory access.
- MC_LAT, 4: cycles a multi-cycle op occupies EX (legal range 1..255).
- LU_BUBBLES, 1: load-use bubbles inserted (1 with MEM->EX forwarding, 2 without).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- pc_change  in  1  branch/jump redirect resolved in EX_STAGE
- load_use_hazard  in  1  ID instr needs result of load in EX
- mc_start  in  1  multi-cycle op present in EX (level, held while EX frozen)
- mem_wait  in  1  data memory not ready this cycle
- stall  out  NSTAGE  stall[i]=1: entrance register of stage i (stall[0]=PC) holds at next edge
- flush  out  NSTAGE  flush[i]=1: entrance register of stage i loads bubble at next edge
- mc_busy  out  1  multi-cycle op holding EX this cycle

Behaviour:
- Reset: rst high clears mc_state to IDLE, mc_cnt to 0, lu_pend to 0; stall, flush, mc_busy are forced to 0 while rst is high. Outputs are combinational from state and inputs, with zero latency.
- Priority (highest first), one source acts per cycle, and lower sources are ignored (upstream re-presents them because their stage is frozen):
  1. mem_wait: stall[0..MEM_STAGE]=1; flush[MEM_STAGE+1]=1 if MEM_STAGE+1<NSTAGE. mc_state and lu_pend hold; mc_cnt keeps counting.
  2. mc stall (mc_state==BUSY, or IDLE with mc_start and MC_LAT>=2): stall[0..EX_STAGE]=1, flush[EX_STAGE+1]=1, mc_busy=1.
  3. pc_change: flush[1..EX_STAGE]=1, no stall; clears lu_pend.
  4. load-use (load_use_hazard or lu_pend): stall[0..1]=1, flush[2]=1.
- mc FSM (IDLE, BUSY, DONE); transitions are blocked only by mem_wait, except BUSY counting:
  - IDLE + mc_start, MC_LAT>=3: go to BUSY, mc_cnt<=MC_LAT-2.
  - IDLE + mc_start, MC_LAT==2: go to DONE.
  - MC_LAT==1: mc_start is ignored; no stall.
  - BUSY: mc_cnt decrements every edge (including under mem_wait); mc_cnt==1 goes to DONE.
  - DONE: no mc stall, mc_start ignored; go to IDLE on first edge with mem_wait=0.
  - Net effect: MC_LAT-1 stall cycles, then the op advances.
- lu_pend (LU_BUBBLES==2 only): set at an edge where load-use acts from load_use_hazard; cleared at the next edge it acts. With LU_BUBBLES==1 it is tied to 0.
- Simultaneous pc_change and mc_start: the mc stall wins; pc_change is re-presented after DONE.
- rst asserted mid-op: the FSM aborts immediately to IDLE.
- Parameter legality: MEM_STAGE>EX_STAGE>=2 and MEM_STAGE<NSTAGE; illegal values are a generate-time error.

Optional Feature:
HAZARD_STATS_EN:
- Defined: adds 32-bit outputs stall_cycles (increments on each cycle with stall[0]=1) and flush_events (increments on each cycle pc_change acts). Both wrap at 2^32, reset to 0 on rst, and are readable as CSR debug counters.
- Undefined: the ports and counters are absent; no other behavioural change.

Test Plan:
- Defaults, pc_change pulse 1 cycle -> flush=5'b00110, stall=0 that cycle only.
- load_use_hazard pulse, LU_BUBBLES=1 -> stall=5'b00011, flush=5'b00100 for 1 cycle. With LU_BUBBLES=2 -> same vectors for 2 cycles. With pc_change in the second cycle -> flush=5'b00110, lu_pend cleared.
- mc_start held, MC_LAT=4 -> stall=5'b00111, flush=5'b01000, mc_busy=1 for exactly 3 cycles; 4th cycle all 0 with state DONE, then IDLE. MC_LAT=1 -> no stall.
- mem_wait for 2 cycles during BUSY with mc_cnt=2 -> stall=5'b01111, flush=5'b10000 both cycles; mc_cnt reaches DONE underneath; afterwards no extra mc stall.
- mc_start and pc_change together -> mc vectors for 3 cycles, then flush=5'b00110 in the DONE cycle.
- rst asserted in BUSY -> all outputs 0 the same cycle; after release with mc_start=0 the state is IDLE. With HAZARD_STATS_EN, counters read 0.
